// File: rtl/servant_gpio_pkg.sv
// Shared definitions for the servant GPIO bank: register offsets and lane-mask helper.
package servant_gpio_pkg;

   localparam logic [2:0] REG_OUT  = 3'd0;
   localparam logic [2:0] REG_SET  = 3'd1;
   localparam logic [2:0] REG_CLR  = 3'd2;
   localparam logic [2:0] REG_TOG  = 3'd3;
   localparam logic [2:0] REG_IN   = 3'd4;
   localparam logic [2:0] REG_IEN  = 3'd5;
   localparam logic [2:0] REG_PEND = 3'd6;

   // Expand each byte-lane enable to eight mask bits.
   function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) begin
         m[b*8 +: 8] = {8{sel[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/servant_gpio_chan.sv
// One GPIO channel: output register with set/clear/toggle aliases, interrupt enable,
// sticky rising-edge pending bits, input synchroniser and output-change strobe.
module servant_gpio_chan
   import servant_gpio_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [2:0]       reg_sel,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic [WIDTH-1:0] wr_mask,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] in_sync,
   output logic [WIDTH-1:0] ien,
   output logic [WIDTH-1:0] pend,
   output logic             upd,
   output logic             irq_next
);

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] ien_q, ien_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] hist_q;
   logic             upd_q;
   logic [WIDTH-1:0] dm;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] rise;

   // Next-state for OUT/IEN/PEND; a fresh rising edge beats a same-cycle W1C.
   always_comb begin
      dm    = wr_dat & wr_mask;
      out_d = out_q;
      ien_d = ien_q;
      clr   = '0;
      if (wr_en) begin
         case (reg_sel)
            REG_OUT:  out_d = (out_q & ~wr_mask) | dm;
            REG_SET:  out_d = out_q | dm;
            REG_CLR:  out_d = out_q & ~dm;
            REG_TOG:  out_d = out_q ^ dm;
            REG_IEN:  ien_d = (ien_q & ~wr_mask) | dm;
            REG_PEND: clr   = dm;
            default:  ;
         endcase
      end
      rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
      pend_d = (pend_q & ~clr) | rise;
   end

   // Register state; upd fires in the first cycle the new output is visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         ien_q  <= '0;
         pend_q <= '0;
         hist_q <= '0;
         upd_q  <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         out_q     <= out_d;
         ien_q     <= ien_d;
         pend_q    <= pend_d;
         upd_q     <= (out_d != out_q);
         sync_q[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign out      = out_q;
   assign in_sync  = sync_q[SYNC_STAGES-1];
   assign ien      = ien_q;
   assign pend     = pend_q;
   assign upd      = upd_q;
   assign irq_next = |(pend_d & ien_d);

endmodule

// File: rtl/servant_gpio_bank.sv
// Multi-channel GPIO bank on a Wishbone slot: one-wait-state ack, channel/register
// decode, registered read mux and a registered OR-reduced interrupt.
module servant_gpio_bank
   import servant_gpio_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int CHANNELS    = 9,
   parameter int SYNC_STAGES = 2,
   localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int AW         = CW + 5
) (
   input  logic                      i_wb_clk,
   input  logic                      i_wb_rst_n,
   input  logic [AW-1:0]             i_wb_adr,
   input  logic [31:0]               i_wb_dat,
   input  logic [3:0]                i_wb_sel,
   input  logic                      i_wb_we,
   input  logic                      i_wb_cyc,
   output logic [31:0]               o_wb_rdt,
   output logic                      o_wb_ack,
   input  logic [CHANNELS*WIDTH-1:0] i_gpio,
   output logic [CHANNELS*WIDTH-1:0] o_gpio,
   output logic [CHANNELS-1:0]       o_gpio_upd,
   output logic                      o_irq
);

   logic             ack_q;
   logic [31:0]      rdt_q;
   logic             irq_q;
   logic             acc;
   logic             wr;
   logic [2:0]       reg_sel;
   logic [CW-1:0]    chan_idx;
   logic             chan_ok;
   logic [31:0]      mask32;
   logic [WIDTH-1:0] sel_val;
   logic [31:0]      rd_word;
   logic             unused_adr;

   logic [WIDTH-1:0] out_arr  [CHANNELS];
   logic [WIDTH-1:0] in_arr   [CHANNELS];
   logic [WIDTH-1:0] ien_arr  [CHANNELS];
   logic [WIDTH-1:0] pend_arr [CHANNELS];
   logic [CHANNELS-1:0] irq_vec;

   // Access is accepted on the edge where ack rises.
   assign acc        = i_wb_cyc & ~ack_q;
   assign wr         = acc & i_wb_we;
   assign reg_sel    = i_wb_adr[4:2];
   assign chan_idx   = i_wb_adr[AW-1:5];
   assign chan_ok    = 32'(chan_idx) < 32'(CHANNELS);
   assign mask32     = sel_to_mask(i_wb_sel);
   assign unused_adr = ^i_wb_adr[1:0];

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      servant_gpio_chan #(
         .WIDTH       (WIDTH),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk      (i_wb_clk),
         .rst_n    (i_wb_rst_n),
         .wr_en    (wr & chan_ok & (chan_idx == CW'(c))),
         .reg_sel  (reg_sel),
         .wr_dat   (i_wb_dat[WIDTH-1:0]),
         .wr_mask  (mask32[WIDTH-1:0]),
         .gpio_in  (i_gpio[c*WIDTH +: WIDTH]),
         .out      (out_arr[c]),
         .in_sync  (in_arr[c]),
         .ien      (ien_arr[c]),
         .pend     (pend_arr[c]),
         .upd      (o_gpio_upd[c]),
         .irq_next (irq_vec[c])
      );
      assign o_gpio[c*WIDTH +: WIDTH] = out_arr[c];
   end

   // Read mux over channels; write-only aliases read back OUT, out-of-range reads 0.
   always_comb begin
      sel_val = '0;
      rd_word = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (chan_idx == CW'(c)) begin
            case (reg_sel)
               REG_OUT, REG_SET, REG_CLR, REG_TOG: sel_val = out_arr[c];
               REG_IN:   sel_val = in_arr[c];
               REG_IEN:  sel_val = ien_arr[c];
               REG_PEND: sel_val = pend_arr[c];
               default:  sel_val = '0;
            endcase
         end
      end
      if (chan_ok) begin
         rd_word[WIDTH-1:0] = sel_val;
      end
   end

   // Bus handshake, registered read data and interrupt.
   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         ack_q <= 1'b0;
         rdt_q <= '0;
         irq_q <= 1'b0;
      end else begin
         ack_q <= i_wb_cyc & ~ack_q;
         rdt_q <= (acc & ~i_wb_we) ? rd_word : 32'd0;
         irq_q <= |irq_vec;
      end
   end

   assign o_wb_ack = ack_q;
   assign o_wb_rdt = rdt_q;
   assign o_irq    = irq_q;

endmodule

// File: tb/tb_servant_gpio_bank.sv
// Self-checking bench for servant_gpio_bank against a register-level reference model.
module tb_servant_gpio_bank;

   localparam int W  = 32;
   localparam int CH = 9;
   localparam int SS = 2;
   localparam int CW = 4;
   localparam int AW = CW + 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [AW-1:0]    adr;
   logic [31:0]      dat;
   logic [3:0]       sel;
   logic             we;
   logic             cyc;
   logic [31:0]      rdt;
   logic             ack;
   logic [CH*W-1:0]  gpio_in;
   logic [CH*W-1:0]  gpio_out;
   logic [CH-1:0]    upd;
   logic             irq;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_out  [CH];
   logic [31:0] m_ien  [CH];
   logic [31:0] m_pend [CH];
   logic [31:0] m_in   [CH];

   always #5 clk = ~clk;

   servant_gpio_bank #(
      .WIDTH       (W),
      .CHANNELS    (CH),
      .SYNC_STAGES (SS)
   ) dut (
      .i_wb_clk   (clk),
      .i_wb_rst_n (rst_n),
      .i_wb_adr   (adr),
      .i_wb_dat   (dat),
      .i_wb_sel   (sel),
      .i_wb_we    (we),
      .i_wb_cyc   (cyc),
      .o_wb_rdt   (rdt),
      .o_wb_ack   (ack),
      .i_gpio     (gpio_in),
      .o_gpio     (gpio_out),
      .o_gpio_upd (upd),
      .o_irq      (irq)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] f_mask(input logic [3:0] s);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
      return m;
   endfunction

   function automatic void m_reset();
      for (int c = 0; c < CH; c++) begin
         m_out[c] = '0; m_ien[c] = '0; m_pend[c] = '0; m_in[c] = '0;
      end
   endfunction

   function automatic void m_write(input int ch, input int rg, input logic [31:0] d,
                                   input logic [3:0] s);
      logic [31:0] m, dm;
      m  = f_mask(s);
      dm = d & m;
      if (ch >= CH) return;
      case (rg)
         0: m_out[ch]  = (m_out[ch] & ~m) | dm;
         1: m_out[ch]  = m_out[ch] | dm;
         2: m_out[ch]  = m_out[ch] & ~dm;
         3: m_out[ch]  = m_out[ch] ^ dm;
         5: m_ien[ch]  = (m_ien[ch] & ~m) | dm;
         6: m_pend[ch] = m_pend[ch] & ~dm;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] f_read(input int ch, input int rg);
      if (ch >= CH) return 32'd0;
      case (rg)
         0, 1, 2, 3: return m_out[ch];
         4: return m_in[ch];
         5: return m_ien[ch];
         6: return m_pend[ch];
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [CH*W-1:0] f_gpio();
      logic [CH*W-1:0] v;
      for (int c = 0; c < CH; c++) v[c*W +: W] = m_out[c];
      return v;
   endfunction

   function automatic logic f_irq();
      logic r;
      r = 1'b0;
      for (int c = 0; c < CH; c++) if ((m_pend[c] & m_ien[c]) != 0) r = 1'b1;
      return r;
   endfunction

   // New stable input values: any 0->1 bit becomes pending.
   function automatic void m_inputs(input logic [CH*W-1:0] v);
      for (int c = 0; c < CH; c++) begin
         m_pend[c] = m_pend[c] | (v[c*W +: W] & ~m_in[c]);
         m_in[c]   = v[c*W +: W];
      end
   endfunction

   // ---------------- bus driver ----------------
   task automatic bus(input int ch, input int rg, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat);
      @(negedge clk);
      adr = AW'((ch << 5) | (rg << 2));
      dat = d; sel = s; we = w; cyc = 1'b1;
      lat = 0; rd = '0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            lat = i; rd = rdt;
            break;
         end
      end
      cyc = 1'b0; we = 1'b0;
      n_cmp++;
      if (lat == 0) begin
         n_err++;
         $display("FAIL bus_ack_timeout ch=%0d reg=%0d: no ack within 4 cycles", ch, rg);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0; gpio_in = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b exp=0", ack); end
      n_cmp++; if (rdt !== 32'd0) begin n_err++; $display("FAIL reset_rdt got=%h exp=0", rdt); end
      n_cmp++; if (gpio_out !== '0) begin n_err++; $display("FAIL reset_gpio got=%h exp=0", gpio_out); end
      n_cmp++; if (upd !== '0) begin n_err++; $display("FAIL reset_upd got=%b exp=0", upd); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
   endtask

   task automatic test_basic();
      logic [31:0] rd; int lat;
      m_write(0, 0, 32'hA5A5A5A5, 4'hF);
      bus(0, 0, 1'b1, 32'hA5A5A5A5, 4'hF, rd, lat);
      n_cmp++; if (lat != 1) begin n_err++; $display("FAIL basic_ack_latency got=%0d exp=1", lat); end
      n_cmp++; if (gpio_out[31:0] !== 32'hA5A5A5A5) begin
         n_err++; $display("FAIL basic_gpio got=%h exp=a5a5a5a5", gpio_out[31:0]); end
      n_cmp++; if (upd !== 9'b000000001) begin
         n_err++; $display("FAIL basic_upd got=%b exp=000000001", upd); end
      @(posedge clk); #1;
      n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL basic_ack_single got=%b exp=0", ack); end
      n_cmp++; if (upd !== '0) begin n_err++; $display("FAIL basic_upd_single got=%b exp=0", upd); end
      bus(0, 0, 1'b0, 32'd0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'hA5A5A5A5) begin
         n_err++; $display("FAIL basic_readback got=%h exp=a5a5a5a5", rd); end
   endtask

   task automatic test_alias();
      logic [31:0] rd; int lat;
      bus(3, 1, 1'b1, 32'h0000000F, 4'hF, rd, lat); m_write(3, 1, 32'h0000000F, 4'hF);
      n_cmp++; if (upd !== 9'h008) begin n_err++; $display("FAIL alias_set_upd got=%b exp=000001000", upd); end
      bus(3, 2, 1'b1, 32'h00000003, 4'hF, rd, lat); m_write(3, 2, 32'h00000003, 4'hF);
      bus(3, 2, 1'b0, 32'd0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'h0000000C) begin n_err++; $display("FAIL alias_clr_read got=%h exp=0000000c", rd); end
      bus(3, 3, 1'b1, 32'hFFFF0000, 4'hF, rd, lat); m_write(3, 3, 32'hFFFF0000, 4'hF);
      n_cmp++; if (upd !== 9'h008) begin n_err++; $display("FAIL alias_tog_upd got=%b exp=000001000", upd); end
      bus(3, 0, 1'b0, 32'd0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'hFFFF000C) begin n_err++; $display("FAIL alias_tog_read got=%h exp=ffff000c", rd); end
      bus(3, 1, 1'b1, 32'h0000000C, 4'hF, rd, lat); m_write(3, 1, 32'h0000000C, 4'hF);
      n_cmp++; if (upd !== '0) begin n_err++; $display("FAIL alias_noop_upd got=%b exp=0", upd); end
      n_cmp++; if (gpio_out[3*W +: W] !== 32'hFFFF000C) begin
         n_err++; $display("FAIL alias_gpio got=%h exp=ffff000c", gpio_out[3*W +: W]); end
   endtask

   task automatic test_bytelane();
      logic [31:0] rd; int lat;
      bus(5, 0, 1'b1, 32'h12345678, 4'b0010, rd, lat); m_write(5, 0, 32'h12345678, 4'b0010);
      n_cmp++; if (gpio_out[5*W +: W] !== 32'h00005600) begin
         n_err++; $display("FAIL lane_gpio got=%h exp=00005600", gpio_out[5*W +: W]); end
      n_cmp++; if (upd !== 9'h020) begin n_err++; $display("FAIL lane_upd got=%b exp=000100000", upd); end
      bus(5, 0, 1'b0, 32'd0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'h00005600) begin n_err++; $display("FAIL lane_read got=%h exp=00005600", rd); end
      bus(5, 0, 1'b1, 32'hFFFFFFFF, 4'b0000, rd, lat); m_write(5, 0, 32'hFFFFFFFF, 4'b0000);
      n_cmp++; if (upd !== '0) begin n_err++; $display("FAIL lane_sel0_upd got=%b exp=0", upd); end
   endtask

   task automatic test_irq();
      logic [31:0] rd; int lat;
      bus(8, 5, 1'b1, 32'h1, 4'hF, rd, lat); m_write(8, 5, 32'h1, 4'hF);
      @(negedge clk); gpio_in[8*W] = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early got=%b exp=0", irq); end
      @(posedge clk); @(posedge clk); #1;
      m_inputs(gpio_in);
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise got=%b exp=1", irq); end
      bus(8, 6, 1'b0, 32'd0, 4'h0, rd, lat);
      n_cmp++; if (rd !== f_read(8, 6)) begin n_err++; $display("FAIL irq_pend_read got=%h exp=%h", rd, f_read(8, 6)); end
      bus(8, 6, 1'b1, 32'h1, 4'hF, rd, lat); m_write(8, 6, 32'h1, 4'hF);
      @(posedge clk); #1;
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_w1c got=%b exp=0", irq); end
      @(negedge clk); gpio_in[8*W] = 1'b0;
      repeat (6) @(posedge clk);
      m_inputs(gpio_in);
      bus(8, 6, 1'b0, 32'd0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL irq_fall_pend got=%h exp=0", rd); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_fall got=%b exp=0", irq); end
   endtask

   task automatic test_race_and_invalid();
      logic [31:0] rd; int lat;
      logic [CH*W-1:0] snap;
      @(negedge clk); gpio_in[8*W] = 1'b1;
      repeat (5) @(posedge clk);
      m_inputs(gpio_in);
      @(negedge clk); gpio_in[8*W] = 1'b0;
      repeat (5) @(posedge clk);
      m_inputs(gpio_in);
      // New rising edge timed to reach PEND on the same edge as the W1C ack.
      @(negedge clk); gpio_in[8*W] = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      adr = AW'((8 << 5) | (6 << 2)); dat = 32'h1; sel = 4'hF; we = 1'b1; cyc = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL race_ack got=%b exp=1", ack); end
      cyc = 1'b0; we = 1'b0;
      m_inputs(gpio_in);
      @(posedge clk); #1;
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL race_irq got=%b exp=1", irq); end
      bus(8, 6, 1'b0, 32'd0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL race_pend got=%h exp=00000001", rd); end
      snap = gpio_out;
      bus(12, 0, 1'b1, 32'hFFFFFFFF, 4'hF, rd, lat);
      n_cmp++; if (gpio_out !== snap) begin n_err++; $display("FAIL bad_chan_gpio got=%h exp=%h", gpio_out, snap); end
      n_cmp++; if (upd !== '0) begin n_err++; $display("FAIL bad_chan_upd got=%b exp=0", upd); end
      bus(12, 0, 1'b0, 32'd0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL bad_chan_read got=%h exp=0", rd); end
   endtask

   task automatic test_random();
      logic [31:0] rd, d;
      logic [3:0]  s;
      logic [31:0] prev [CH];
      logic [CH-1:0] exp_upd;
      logic w;
      int lat, ch, rg;
      for (int ph = 0; ph < 2; ph++) begin
         @(negedge clk);
         for (int c = 0; c < CH; c++) gpio_in[c*W +: W] = $urandom();
         repeat (5) @(posedge clk);
         m_inputs(gpio_in);
         for (int n = 0; n < 40; n++) begin
            ch = $urandom_range(0, 9);
            if (ch == 9) ch = $urandom_range(9, 15);
            rg = $urandom_range(0, 7);
            w  = 1'($urandom_range(0, 1));
            d  = $urandom();
            s  = 4'($urandom_range(0, 15));
            if (w) begin
               for (int c = 0; c < CH; c++) prev[c] = m_out[c];
               m_write(ch, rg, d, s);
               for (int c = 0; c < CH; c++) exp_upd[c] = (prev[c] != m_out[c]);
               bus(ch, rg, 1'b1, d, s, rd, lat);
               n_cmp++; if (gpio_out !== f_gpio()) begin
                  n_err++; $display("FAIL rand_gpio ch=%0d reg=%0d got=%h exp=%h", ch, rg, gpio_out, f_gpio()); end
               n_cmp++; if (upd !== exp_upd) begin
                  n_err++; $display("FAIL rand_upd ch=%0d reg=%0d got=%b exp=%b", ch, rg, upd, exp_upd); end
               @(posedge clk); #1;
               n_cmp++; if (irq !== f_irq()) begin
                  n_err++; $display("FAIL rand_irq ch=%0d reg=%0d got=%b exp=%b", ch, rg, irq, f_irq()); end
            end else begin
               bus(ch, rg, 1'b0, d, s, rd, lat);
               n_cmp++; if (rd !== f_read(ch, rg)) begin
                  n_err++; $display("FAIL rand_read ch=%0d reg=%0d got=%h exp=%h", ch, rg, rd, f_read(ch, rg)); end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; int lat;
      // Make sure outputs and interrupt are active so the reset effect is visible.
      bus(0, 0, 1'b1, 32'h0000FFFF, 4'hF, rd, lat); m_write(0, 0, 32'h0000FFFF, 4'hF);
      bus(8, 5, 1'b1, 32'hFFFFFFFF, 4'hF, rd, lat); m_write(8, 5, 32'hFFFFFFFF, 4'hF);
      bus(8, 6, 1'b0, 32'd0, 4'h0, rd, lat);
      m_pend[8] = m_pend[8];
      @(posedge clk); #1;
      n_cmp++; if (irq !== f_irq()) begin n_err++; $display("FAIL rmid_pre_irq got=%b exp=%b", irq, f_irq()); end
      @(negedge clk);
      adr = AW'((1 << 5) | (0 << 2)); dat = 32'hDEADBEEF; sel = 4'hF; we = 1'b1; cyc = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rmid_ack got=%b exp=0", ack); end
      n_cmp++; if (gpio_out !== '0) begin n_err++; $display("FAIL rmid_gpio got=%h exp=0", gpio_out); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rmid_irq got=%b exp=0", irq); end
      @(posedge clk);
      @(negedge clk);
      cyc = 1'b0; we = 1'b0; gpio_in = '0;
      m_reset();
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (gpio_out !== '0) begin n_err++; $display("FAIL rmid_post_gpio got=%h exp=0", gpio_out); end
      bus(1, 0, 1'b0, 32'd0, 4'h0, rd, lat);
      n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL rmid_discard got=%h exp=0", rd); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rmid_post_irq got=%b exp=0", irq); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_alias();
      test_bytelane();
      test_irq();
      test_race_and_invalid();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
